// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 7-segment display driver.
// Scans one digit per refresh slot, with leading-zero blanking, per-digit
// decimal points and frame-synchronous blink. New values arrive through a
// valid/ready handshake and take effect only at a frame boundary, so a frame
// never shows a mix of old and new digits.
module sseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1024,
  parameter int BLINK_FRAMES = 64,
  parameter int SEG_ACT_LOW  = 0,
  parameter int AN_ACT_LOW   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);
  localparam logic             SEG_INV  = (SEG_ACT_LOW != 0);
  localparam logic             AN_INV   = (AN_ACT_LOW != 0);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        scan_idx;
  logic [FR_W-1:0]         frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_full;
  logic                    tick;
  logic                    frame_end;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_run;
  logic                    run;
  logic [3:0]              cur_nib;
  logic                    blank_cur;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick       = (div_cnt == DIV_LAST);
  assign frame_end  = tick && (scan_idx == IDX_LAST);
  assign load_ready = !pending_full;

  // Slot timer and digit scan pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
  end

  // Pending buffer: accept when empty, commit to display at frame end.
  // Accept and commit are mutually exclusive since one needs the buffer
  // empty and the other needs it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= '0;
      pending_full <= 1'b0;
      display      <= '0;
    end else if (frame_end && pending_full) begin
      display      <= pending;
      pending_full <= 1'b0;
    end else if (load_valid && !pending_full) begin
      pending      <= load_value;
      pending_full <= 1'b1;
    end
  end

  // Blink timebase: free-running frame counter, phase toggles on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt == FR_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Next output pattern for the current digit: decode, blanking, blink.
  always_comb begin
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]    = display[4*i +: 4];
      run       = run && (nib[i] == 4'h0);
      lz_run[i] = run;
    end
    cur_nib   = nib[scan_idx];
    blank_cur = blank_lz && (scan_idx != '0) && lz_run[scan_idx];
    an_n           = '0;
    an_n[scan_idx] = 1'b1;
    seg_n     = blank_cur ? 7'h00 : hex7(cur_nib);
    dp_n      = dp_mask[scan_idx];
    if (blink_en && blink_phase) begin
      an_n  = '0;
      seg_n = 7'h00;
      dp_n  = 1'b0;
    end
  end

  // Output register; all pins update on the same edge, polarity applied last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sseg  <= {7{SEG_INV}};
      dp    <= SEG_INV;
      anode <= {NUM_DIGITS{AN_INV}};
    end else begin
      sseg  <= seg_n ^ {7{SEG_INV}};
      dp    <= dp_n ^ SEG_INV;
      anode <= an_n ^ {NUM_DIGITS{AN_INV}};
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with 4 digits, 4-cycle slots and
// 2-frame blink half-period. Cycle numbers count rising edges since the
// last reset release; frame ends fall on cycles 16, 32, 48, ...
module tb_sseg_scan_driver;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  sseg;
  logic        dp;
  logic [3:0]  anode;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  sseg_scan_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2),
    .SEG_ACT_LOW (0),
    .AN_ACT_LOW  (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .sseg      (sseg),
    .dp        (dp),
    .anode     (anode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic d);
    chk({tag, ".anode"}, anode, an);
    chk({tag, ".sseg"}, sseg, sg);
    chk({tag, ".dp"}, dp, d);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    reset      = 1'b1;
    load_valid = 1'b0;
    load_value = 16'h0000;
    dp_mask    = 4'b0000;
    blank_lz   = 1'b0;
    blink_en   = 1'b0;
    #2;
    chk_out({tag, ".rst"}, 4'b0000, 7'h00, 1'b0);
    chk({tag, ".rst.ready"}, load_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_value = '0;
    dp_mask = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    #20;

    // 1: basic load, hidden until first frame end
    do_reset("t1");
    load_value = 16'h12AF;
    load_valid = 1'b1;
    at_cyc(1);
    load_valid = 1'b0;
    chk("t1.ready_drop", load_ready, 1'b0);
    chk_out("t1.c1", 4'b0001, 7'h3F, 1'b0);
    at_cyc(13); chk_out("t1.hidden", 4'b1000, 7'h3F, 1'b0);
    at_cyc(15); chk("t1.ready15", load_ready, 1'b0);
    at_cyc(16); chk("t1.ready16", load_ready, 1'b1);
    chk_out("t1.c16", 4'b1000, 7'h3F, 1'b0);
    at_cyc(17); chk_out("t1.d0", 4'b0001, 7'h71, 1'b0);
    at_cyc(20); chk_out("t1.d0end", 4'b0001, 7'h71, 1'b0);
    at_cyc(21); chk_out("t1.d1", 4'b0010, 7'h77, 1'b0);
    at_cyc(25); chk_out("t1.d2", 4'b0100, 7'h5B, 1'b0);
    at_cyc(29); chk_out("t1.d3", 4'b1000, 7'h06, 1'b0);

    // 2: leading-zero blanking
    do_reset("t2");
    blank_lz = 1'b1;
    load_value = 16'h0040;
    load_valid = 1'b1;
    at_cyc(1);
    load_valid = 1'b0;
    chk_out("t2.c1", 4'b0001, 7'h3F, 1'b0);
    at_cyc(5); chk_out("t2.zero_d1", 4'b0010, 7'h00, 1'b0);
    at_cyc(16);
    load_value = 16'h0000;
    load_valid = 1'b1;
    at_cyc(17);
    load_valid = 1'b0;
    chk("t2.ready17", load_ready, 1'b0);
    chk_out("t2.d0", 4'b0001, 7'h3F, 1'b0);
    at_cyc(21); chk_out("t2.d1", 4'b0010, 7'h66, 1'b0);
    at_cyc(25); chk_out("t2.d2", 4'b0100, 7'h00, 1'b0);
    at_cyc(29); chk_out("t2.d3", 4'b1000, 7'h00, 1'b0);
    at_cyc(33); chk_out("t2.z_d0", 4'b0001, 7'h3F, 1'b0);
    at_cyc(37); chk_out("t2.z_d1", 4'b0010, 7'h00, 1'b0);

    // 3: valid held across two values
    do_reset("t3");
    load_value = 16'h1111;
    load_valid = 1'b1;
    at_cyc(1);
    load_value = 16'h2222;
    at_cyc(2); chk("t3.ready2", load_ready, 1'b0);
    at_cyc(16); chk("t3.ready16", load_ready, 1'b1);
    at_cyc(17);
    load_valid = 1'b0;
    chk("t3.ready17", load_ready, 1'b0);
    chk_out("t3.d0", 4'b0001, 7'h06, 1'b0);
    at_cyc(29); chk_out("t3.d3", 4'b1000, 7'h06, 1'b0);
    at_cyc(33); chk_out("t3.new_d0", 4'b0001, 7'h5B, 1'b0);

    // 4: load accepted on a frame-end cycle
    do_reset("t4");
    at_cyc(15);
    load_value = 16'h00C3;
    load_valid = 1'b1;
    at_cyc(16);
    load_valid = 1'b0;
    chk("t4.ready16", load_ready, 1'b0);
    at_cyc(17); chk_out("t4.old_d0", 4'b0001, 7'h3F, 1'b0);
    at_cyc(31); chk("t4.ready31", load_ready, 1'b0);
    at_cyc(32); chk("t4.ready32", load_ready, 1'b1);
    at_cyc(33); chk_out("t4.d0", 4'b0001, 7'h4F, 1'b0);
    at_cyc(37); chk_out("t4.d1", 4'b0010, 7'h39, 1'b0);

    // 5: blink with decimal point on digit 2 (display 0, blanking on)
    do_reset("t5");
    blink_en = 1'b1;
    blank_lz = 1'b1;
    dp_mask  = 4'b0100;
    at_cyc(1);  chk_out("t5.f0d0", 4'b0001, 7'h3F, 1'b0);
    at_cyc(9);  chk_out("t5.f0d2", 4'b0100, 7'h00, 1'b1);
    at_cyc(12); chk_out("t5.f0d2e", 4'b0100, 7'h00, 1'b1);
    at_cyc(13); chk_out("t5.f0d3", 4'b1000, 7'h00, 1'b0);
    at_cyc(25); chk_out("t5.f1d2", 4'b0100, 7'h00, 1'b1);
    at_cyc(32); chk_out("t5.f1end", 4'b1000, 7'h00, 1'b0);
    at_cyc(33); chk_out("t5.off0", 4'b0000, 7'h00, 1'b0);
    at_cyc(41); chk_out("t5.offd2", 4'b0000, 7'h00, 1'b0);
    at_cyc(64); chk_out("t5.off_end", 4'b0000, 7'h00, 1'b0);
    at_cyc(65); chk_out("t5.on_again", 4'b0001, 7'h3F, 1'b0);
    at_cyc(73); chk_out("t5.on_d2", 4'b0100, 7'h00, 1'b1);
    at_cyc(99); chk_out("t5.off2", 4'b0000, 7'h00, 1'b0);
    blink_en = 1'b0;
    at_cyc(100); chk_out("t5.blink_off", 4'b0001, 7'h3F, 1'b0);

    // 6: asynchronous reset mid-slot with pending full
    do_reset("t6");
    load_value = 16'h1234;
    load_valid = 1'b1;
    at_cyc(1);
    load_valid = 1'b0;
    at_cyc(6);
    chk_out("t6.pre", 4'b0010, 7'h3F, 1'b0);
    chk("t6.pre.ready", load_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("t6.async", 4'b0000, 7'h00, 1'b0);
    chk("t6.async.ready", load_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    at_cyc(1);  chk_out("t6.c1", 4'b0001, 7'h3F, 1'b0);
    chk("t6.ready1", load_ready, 1'b1);
    at_cyc(17); chk_out("t6.nocommit", 4'b0001, 7'h3F, 1'b0);
    at_cyc(21); chk_out("t6.nocommit_d1", 4'b0010, 7'h3F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
